// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared types and constants for the Nibbler I/O port select logic.
//   io_state_t     : FSM state of io_select_decoder (IDLE / ACTIVE)
//   IO_MODE_PULSE  : enable is held for a fixed number of cycles
//   IO_MODE_LEVEL  : enable is held for as long as load stays high
// -----------------------------------------------------------------------------
package io_pkg;

    typedef enum logic {
        IO_IDLE   = 1'b0,
        IO_ACTIVE = 1'b1
    } io_state_t;

    localparam logic IO_MODE_PULSE = 1'b0;
    localparam logic IO_MODE_LEVEL = 1'b1;

endpackage : io_pkg

// File: rtl/io_select_decoder_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Purely combinational binary-to-one-hot decoder.
//   sel     in   SEL_W      binary port number
//   onehot  out  NUM_PORTS  one-hot decode of sel, all zero when out of range
//   valid   out  1          sel < NUM_PORTS (unsigned)
// -----------------------------------------------------------------------------
module onehot_dec #(
    parameter int SEL_W     = 4,
    parameter int NUM_PORTS = 16
) (
    input  logic [SEL_W-1:0]     sel,
    output logic [NUM_PORTS-1:0] onehot,
    output logic                 valid
);

    // Only indices below NUM_PORTS are decoded, so an out-of-range sel
    // naturally produces an all-zero vector.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == SEL_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

    // Compare one bit wider than sel so NUM_PORTS == 2**SEL_W is representable;
    // in that configuration valid is constantly 1.
    assign valid = ({1'b0, sel} < (SEL_W + 1)'(NUM_PORTS));

endmodule : onehot_dec

// File: rtl/io_select_decoder.sv
// -----------------------------------------------------------------------------
// io_select_decoder
// Registered binary-to-one-hot I/O port select for the Nibbler I/O bus, with a
// timed-strobe (PULSE) mode and a held (LEVEL) mode.
//
// Ports
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          synchronous active-low reset
//   load         in   1          request: decode sel this cycle
//   sel          in   SEL_W      binary port number
//   level_mode   in   1          0 = PULSE, 1 = LEVEL (sampled on acceptance)
//   clr_err      in   1          clears sticky error flags
//   onehot       out  NUM_PORTS  registered port enables, at most one bit set
//   busy         out  1          high while an enable is active
//   done         out  1          one-cycle pulse when an enable drops
//   err_range    out  1          sticky: request with sel >= NUM_PORTS
//   err_overrun  out  1          sticky: load seen in PULSE ACTIVE (dropped)
//   dbg_state    out  io_state_t current FSM state, for observation only
//
// Handshake: load is a request that is accepted only in IDLE (including the
// cycle in which done is high). busy is high exactly while an enable is
// driven. done pulses for one cycle on the cycle after the enable drops, and a
// load presented in that cycle starts the next access with no gap cycle.
// -----------------------------------------------------------------------------
module io_select_decoder
    import io_pkg::*;
#(
    parameter int SEL_W      = 4,
    parameter int NUM_PORTS  = 16,
    parameter int STROBE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 level_mode,
    input  logic                 clr_err,
    output logic [NUM_PORTS-1:0] onehot,
    output logic                 busy,
    output logic                 done,
    output logic                 err_range,
    output logic                 err_overrun,
    output io_state_t            dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    io_state_t            state_q, state_d;
    logic                 mode_q, mode_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] onehot_q, onehot_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_range_q, err_range_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 range_set;
    logic                 overrun_set;

    logic [NUM_PORTS-1:0] dec_onehot;
    logic                 dec_valid;

    onehot_dec #(
        .SEL_W     (SEL_W),
        .NUM_PORTS (NUM_PORTS)
    ) u_dec (
        .sel    (sel),
        .onehot (dec_onehot),
        .valid  (dec_valid)
    );

    // Next-state / next-output logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        onehot_d    = onehot_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        range_set   = 1'b0;
        overrun_set = 1'b0;

        if (state_q == IO_IDLE) begin
            onehot_d = '0;
            busy_d   = 1'b0;
            if (load) begin
                if (dec_valid) begin
                    // The registered one-hot vector is the latched port
                    // number; later sel changes cannot disturb it.
                    state_d  = IO_ACTIVE;
                    mode_d   = level_mode;
                    cnt_d    = CNT_ONE;
                    onehot_d = dec_onehot;
                    busy_d   = 1'b1;
                end else begin
                    range_set = 1'b1;
                end
            end
        end else begin
            if (mode_q == IO_MODE_LEVEL) begin
                if (load) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d  = IO_IDLE;
                    onehot_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                end
            end else begin
                // Any request while a strobe runs is discarded and flagged.
                if (load) begin
                    overrun_set = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d  = IO_IDLE;
                    onehot_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end

        // Sticky flags: a new error in the same cycle beats clr_err.
        err_range_d   = (err_range_q   & ~clr_err) | range_set;
        err_overrun_d = (err_overrun_q & ~clr_err) | overrun_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IO_IDLE;
            mode_q        <= IO_MODE_PULSE;
            cnt_q         <= '0;
            onehot_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            onehot_q      <= onehot_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_range_q   <= err_range_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign onehot      = onehot_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_range   = err_range_q;
    assign err_overrun = err_overrun_q;
    assign dbg_state   = state_q;

endmodule : io_select_decoder
